ntt_stage_scheduler: RTL and testbench

- Sequences one full 1024-point NTT pass over the d=4 parallel butterfly datapath.
- Walks the stage loop J = 512, 256, ..., 1 and the issue counter within each stage.
- Per issue slot it emits the J/i pair consumed by the twiddle address generator, plus four butterfly top-operand addresses.
- Inserts a pipeline-drain barrier between stages so stage s+1 never reads data still in flight from stage s.

---
 rtl/ntt_pkg.sv | 14 +
 rtl/ntt_bf_addr_calc.sv | 21 ++
 rtl/ntt_stage_scheduler.sv | 84 ++++++++
 tb/tb_ntt_stage_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, FSM encoding and twiddle base offsets for the NTT stage loop
package ntt_pkg;
  localparam int N = 1024;
  localparam int D = 4;
  localparam int LOGN = 10;
  localparam int PIPE_LAT = 6;
  localparam int AW = $clog2(N);
  localparam int CNT_W = $clog2(N / (2 * D));
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  // Start of each stage's twiddle block: 0,128,192,...,254 then 255,256 for the single-entry stages
  function automatic logic [8:0] tf_base(input logic [3:0] stage);
    return stage < 4'd8 ? 9'd256 - (9'd256 >> stage) : 9'd247 + 9'(stage);
  endfunction
endpackage

// File: rtl/ntt_bf_addr_calc.sv
// ntt_bf_addr_calc: combinational top-operand addresses and twiddle group index for one issue slot
module ntt_bf_addr_calc
  import ntt_pkg::*;
(
  input  logic [CNT_W-1:0]  cnt,
  input  logic [3:0]        stage,
  output logic [D*AW-1:0]   top_addr,
  output logic [CNT_W-1:0]  i
);
  logic [AW-1:0] mask;
  logic [3:0] sh;
  assign mask = (AW'(N / 2) >> stage) - AW'(1);
  assign sh = 4'(LOGN - 1) - stage;
  assign i = cnt >> stage;
  // top = (k / J) * 2J + (k mod J), with J = 2^sh
  for (genvar l = 0; l < D; l++) begin : g_lane
    logic [AW-1:0] k;
    assign k = {1'b0, cnt, 2'(l)};
    assign top_addr[AW*l +: AW] = ((k >> sh) << (sh + 4'd1)) | (k & mask);
  end
endmodule

// File: rtl/ntt_stage_scheduler.sv
// ntt_stage_scheduler: sequences the 10 NTT stages over the 4-lane butterfly pipe with a drain between stages
module ntt_stage_scheduler
  import ntt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bf_ready,
  output logic              bf_valid,
  output logic [AW-1:0]     J,
  output logic [CNT_W-1:0]  i,
  output logic [D*AW-1:0]   top_addr,
  output logic [3:0]        stage,
  output logic              busy,
  output logic              done
);
  localparam int DW = $clog2(PIPE_LAT);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, i_nxt;
  logic [3:0] stage_nxt;
  logic [DW-1:0] drain, drain_nxt;
  logic [D*AW-1:0] top_nxt;
  // Addresses are computed from next-state values so the registered outputs line up with ISSUE
  ntt_bf_addr_calc u_calc (
    .cnt(cnt_nxt),
    .stage(stage_nxt),
    .top_addr(top_nxt),
    .i(i_nxt)
  );
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    stage_nxt = stage;
    drain_nxt = drain;
    unique case (state)
      IDLE: if (start) begin
        state_nxt = ISSUE;
        cnt_nxt = '0;
        stage_nxt = '0;
      end
      ISSUE: if (bf_ready) begin
        if (cnt == '1) begin
          state_nxt = DRAIN;
          drain_nxt = '0;
        end else cnt_nxt = cnt + 1'b1;
      end
      DRAIN: if (drain == DW'(PIPE_LAT - 1)) begin
        if (stage == 4'(LOGN - 1)) state_nxt = DONE;
        else begin
          state_nxt = ISSUE;
          stage_nxt = stage + 1'b1;
          cnt_nxt = '0;
        end
      end else drain_nxt = drain + 1'b1;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      stage <= '0;
      drain <= '0;
      bf_valid <= 1'b0;
      J <= AW'(N / 2);
      i <= '0;
      top_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      stage <= stage_nxt;
      drain <= drain_nxt;
      bf_valid <= state_nxt == ISSUE;
      J <= AW'(N / 2) >> stage_nxt;
      i <= i_nxt;
      top_addr <= top_nxt;
      busy <= state_nxt == ISSUE || state_nxt == DRAIN;
      done <= state_nxt == DONE;
    end
  end
endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// tb_ntt_stage_scheduler: directed and random-ready checks of the NTT stage scheduler
module tb_ntt_stage_scheduler;
  logic clk = 0, rst_n = 0, start = 0, bf_ready = 1;
  logic bf_valid, busy, done;
  logic [9:0] J;
  logic [6:0] i;
  logic [39:0] top_addr;
  logic [3:0] stage;
  int checks = 0, errors = 0, cyc = 0;
  int seen [10][1024];
  int mc, ms, acc, bad, t, jj;
  logic hs, held, saw_done;
  logic [39:0] hold_top;
  logic [9:0] hold_j;
  logic [6:0] hold_i;

  ntt_stage_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bf_ready(bf_ready),
    .bf_valid(bf_valid), .J(J), .i(i), .top_addr(top_addr),
    .stage(stage), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, bf_valid, 0);
    chk({tag, "_J"}, J, 512);
    chk({tag, "_i"}, i, 0);
    chk({tag, "_top"}, top_addr, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  function automatic logic [39:0] ref_top(input int c, input int s);
    logic [39:0] r;
    int j, k, v;
    j = 512 >> s;
    for (int l = 0; l < 4; l++) begin
      k = 4 * c + l;
      v = (k / j) * 2 * j + k % j;
      r[10*l +: 10] = 10'(v);
    end
    return r;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1;
    tick;
    // Pass 1: bf_ready held high
    cyc = 0;
    start = 1;
    tick;
    start = 0;
    chk("first_valid", bf_valid, 1);
    chk("first_J", J, 512);
    chk("first_i", i, 0);
    chk("first_top", top_addr, {10'd3, 10'd2, 10'd1, 10'd0});
    chk("first_busy", busy, 1);
    while (cyc < 128) tick;
    chk("s0_last_top", top_addr, {10'd511, 10'd510, 10'd509, 10'd508});
    chk("s0_last_i", i, 127);
    chk("s0_last_valid", bf_valid, 1);
    tick;
    for (int d = 0; d < 6; d++) begin
      chk("drain_valid", bf_valid, 0);
      tick;
    end
    chk("s1_valid", bf_valid, 1);
    chk("s1_stage", stage, 1);
    chk("s1_J", J, 256);
    chk("s1_i", i, 0);
    chk("s1_top", top_addr, {10'd3, 10'd2, 10'd1, 10'd0});
    start = 1;
    tick;
    start = 0;
    while (cyc < 1073) tick;
    chk("s8_stage", stage, 8);
    chk("s8_J", J, 2);
    chk("s8_top", top_addr, {10'd5, 10'd4, 10'd1, 10'd0});
    chk("s8_i", i, 0);
    while (cyc < 1208) tick;
    chk("s9_stage", stage, 9);
    chk("s9_J", J, 1);
    chk("s9_top", top_addr, {10'd14, 10'd12, 10'd10, 10'd8});
    chk("s9_i", i, 0);
    while (!done && cyc < 1400) tick;
    chk("pass1_latency", cyc, 1 + 10 * (128 + 6) + 1 - 1);
    chk("pass1_done", done, 1);
    chk("pass1_busy_at_done", busy, 0);
    start = 1;
    tick;
    start = 0;
    chk("after_done_pulse", done, 0);
    chk("after_done_busy", busy, 0);
    tick;
    chk("start_on_done_ignored_busy", busy, 0);
    chk("start_on_done_ignored_valid", bf_valid, 0);
    // Pass 2: random bf_ready against an independent address model
    for (int s = 0; s < 10; s++) for (int x = 0; x < 1024; x++) seen[s][x] = 0;
    cyc = 0;
    start = 1;
    tick;
    start = 0;
    mc = 0;
    ms = 0;
    acc = 0;
    bad = 0;
    while (!done && cyc < 20000) begin
      bf_ready = 1'($urandom_range(0, 1));
      if (bf_valid) begin
        chk("rnd_top", top_addr, ref_top(mc, ms));
        chk("rnd_J", J, 512 >> ms);
        chk("rnd_i", i, mc >> ms);
      end
      hs = bf_valid && bf_ready;
      held = bf_valid && !bf_ready;
      hold_top = top_addr;
      hold_j = J;
      hold_i = i;
      if (hs) begin
        acc++;
        jj = 512 >> ms;
        for (int l = 0; l < 4; l++) begin
          t = int'(top_addr[10*l +: 10]);
          if (ms < 10 && t + jj < 1024) begin
            seen[ms][t]++;
            seen[ms][t + jj]++;
          end else bad++;
        end
        if (mc == 127) begin
          mc = 0;
          ms++;
        end else mc++;
      end
      tick;
      if (held) chk("hold", {bf_valid, J, i, top_addr}, {1'b1, hold_j, hold_i, hold_top});
    end
    bf_ready = 1;
    chk("rnd_done", done, 1);
    chk("rnd_accepted", acc, 1280);
    for (int s = 0; s < 10; s++) for (int x = 0; x < 1024; x++) if (seen[s][x] != 1) bad++;
    chk("rnd_coverage", bad, 0);
    tick;
    tick;
    // Pass 3: asynchronous reset during stage 4, then a clean pass
    cyc = 0;
    start = 1;
    tick;
    start = 0;
    while (stage != 4 && cyc < 2000) tick;
    repeat (20) tick;
    chk("mid_stage4", stage, 4);
    #2;
    rst_n = 0;
    #1;
    chk_reset("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1;
    saw_done = 0;
    repeat (1400) begin
      tick;
      if (done || busy) saw_done = 1;
    end
    chk("no_done_after_abort", saw_done, 0);
    cyc = 0;
    start = 1;
    tick;
    start = 0;
    while (!done && cyc < 1400) tick;
    chk("pass3_latency", cyc, 1 + 10 * (128 + 6) + 1 - 1);
    chk("pass3_done", done, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
